rst_manager: RTL



---
 rtl/rst_manager.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rst_manager.sv
// rst_manager: merges the power-on/pad reset with the watchdog, SYSRESETREQ and
// LOCKUP requests into one registered active-low system reset (RESETn), stretched
// to at least HOLD_CYCLES clocks. It also keeps sticky reset-cause bits and a
// saturating run-time reset counter; only power-on or CAUSE_CLR clears them.
//
// state_dbg mirrors the FSM state register (0 = HOLD, 1 = RUN) for observation.
module rst_manager #(
  parameter int HOLD_CYCLES     = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int LOCKUP_RESET_EN = 1
) (
  input  logic       SYS_FCLK,
  input  logic       RESET,
  input  logic       WDOGRES,
  input  logic       SYSRESETREQ,
  input  logic       LOCKUP,
  input  logic       CAUSE_CLR,
  output logic       RESETn,
  output logic [3:0] RESET_CAUSE,
  output logic [7:0] RST_COUNT,
  output logic       state_dbg
);

  localparam int            CW      = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST    = CW'(HOLD_CYCLES - 1);
  localparam bit            LOCK_EN = (LOCKUP_RESET_EN != 0);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] wdog_sync;
  logic [SYNC_STAGES-1:0] sys_sync;
  logic [SYNC_STAGES-1:0] lock_sync;

  logic req_wdog;
  logic req_sys;
  logic req_lock;
  logic req;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          resetn_q, resetn_d;
  logic [3:0]    cause_q, cause_d;
  logic [7:0]    count_q, count_d;
  logic          entry;

  // Request synchronizers: one shift chain per asynchronous request input.
  always_ff @(posedge SYS_FCLK or posedge RESET) begin
    if (RESET) begin
      wdog_sync <= '0;
      sys_sync  <= '0;
      lock_sync <= '0;
    end else begin
      wdog_sync <= {wdog_sync[SYNC_STAGES-2:0], WDOGRES};
      sys_sync  <= {sys_sync[SYNC_STAGES-2:0], SYSRESETREQ};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], LOCKUP};
    end
  end

  assign req_wdog = wdog_sync[SYNC_STAGES-1];
  assign req_sys  = sys_sync[SYNC_STAGES-1];
  assign req_lock = LOCK_EN & lock_sync[SYNC_STAGES-1];
  assign req      = req_wdog | req_sys | req_lock;

  // Next-state, hold counter, cause bits and reset counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    entry   = 1'b0;
    case (state_q)
      HOLD: begin
        if (req) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (req) begin
          state_d = HOLD;
          cnt_d   = '0;
          entry   = 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase

    // A clear in the same cycle as a new cause leaves only the new cause bits.
    cause_d = (CAUSE_CLR ? 4'b0000 : cause_q) | {req_lock, req_sys, req_wdog, 1'b0};

    // A RUN-to-HOLD entry counts once even with several sources; it beats a clear.
    if (entry) begin
      if (CAUSE_CLR)
        count_d = 8'd1;
      else if (count_q == 8'hFF)
        count_d = count_q;
      else
        count_d = count_q + 8'd1;
    end else if (CAUSE_CLR) begin
      count_d = 8'd0;
    end else begin
      count_d = count_q;
    end

    resetn_d = (state_d == RUN);
  end

  // State and output registers; RESET forces the power-on values immediately.
  always_ff @(posedge SYS_FCLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      resetn_q <= 1'b0;
      cause_q  <= 4'b0001;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      resetn_q <= resetn_d;
      cause_q  <= cause_d;
      count_q  <= count_d;
    end
  end

  assign RESETn      = resetn_q;
  assign RESET_CAUSE = cause_q;
  assign RST_COUNT   = count_q;
  assign state_dbg   = state_q;

endmodule
